// File: rtl/clk_mon_pkg.sv
// Shared constants for the divided-clock monitor: FSM state encoding and
// error codes reported on err_code.
package clk_mon_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACQ  = 3'd1;
    localparam logic [2:0] ST_MEAS = 3'd2;
    localparam logic [2:0] ST_LOCK = 3'd3;
    localparam logic [2:0] ST_FAIL = 3'd4;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_PERIOD = 2'd1;
    localparam logic [1:0] ERR_DUTY   = 2'd2;
    localparam logic [1:0] ERR_STUCK  = 2'd3;

endpackage

// File: rtl/clk_mon_sync_edge_det.sv
// Brings the asynchronous monitored clock into the clk domain and detects its
// rising edge. lvl is the synchronized level, rise a one-cycle pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise
);

    logic s1, s2, s3;

    // Two-flop synchronizer followed by a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures period and high time of mon_clk in clk
// cycles, declares lock after LOCK_CNT consecutive good periods and raises a
// sticky error on bad period, bad duty or a stuck clock.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int DIV      = 3,
    parameter int CW       = 8,
    parameter int LOCK_CNT = 4,
    parameter int TMO      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mon_clk,
    input  logic          err_clr,
    output logic          locked,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [CW-1:0] period,
    output logic          period_vld
);

    localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] DIV_C  = CW'(DIV);
    localparam logic [CW-1:0] TMO_C  = CW'(TMO);
    localparam logic [CW-1:0] HI_MIN = CW'(DIV / 2);
    localparam logic [CW-1:0] HI_MAX = CW'((DIV + 1) / 2);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);

    logic          s2, rise;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cyc_q, hi_q;
    logic [GW-1:0] good_q, good_d;
    logic          locked_d, err_d, rpt;
    logic [1:0]    code_d;
    logic          per_ok, duty_ok;

    // Saturating increment so long gaps never wrap back into a "good" count
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic inc);
        if (inc && (a != '1))
            return a + ONE;
        return a;
    endfunction

    sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (mon_clk),
        .lvl  (s2),
        .rise (rise)
    );

    assign per_ok  = (cyc_q == DIV_C);
    assign duty_ok = (hi_q >= HI_MIN) && (hi_q <= HI_MAX);

    // Period and high-time counters; held at zero while idle or failed so that
    // re-entering ACQ always times out from the moment of entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            hi_q  <= '0;
        end else if (state_q == ST_IDLE || state_q == ST_FAIL) begin
            cyc_q <= '0;
            hi_q  <= '0;
        end else if (rise) begin
            cyc_q <= ONE;
            hi_q  <= ONE;
        end else begin
            cyc_q <= sat_add(cyc_q, 1'b1);
            hi_q  <= sat_add(hi_q, s2);
        end
    end

    // Next-state logic: lock qualification, error classification, enable override
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        locked_d = locked;
        err_d    = err;
        code_d   = err_code;
        rpt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en)
                    state_d = ST_ACQ;
            end
            ST_ACQ: begin
                if (rise) begin
                    state_d = ST_MEAS;
                    good_d  = '0;
                end else if (cyc_q == TMO_C) begin
                    state_d  = ST_FAIL;
                    locked_d = 1'b0;
                    err_d    = 1'b1;
                    code_d   = ERR_STUCK;
                end
            end
            ST_MEAS, ST_LOCK: begin
                if (rise) begin
                    rpt = 1'b1;
                    if (per_ok && duty_ok) begin
                        if (state_q == ST_MEAS) begin
                            if (good_q == LOCK_LAST) begin
                                state_d  = ST_LOCK;
                                locked_d = 1'b1;
                            end else begin
                                good_d = good_q + GW'(1);
                            end
                        end
                    end else begin
                        state_d  = ST_FAIL;
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                        code_d   = per_ok ? ERR_DUTY : ERR_PERIOD;
                    end
                end else if (cyc_q == TMO_C) begin
                    state_d  = ST_FAIL;
                    locked_d = 1'b0;
                    err_d    = 1'b1;
                    code_d   = ERR_STUCK;
                end
            end
            ST_FAIL: begin
                if (err_clr) begin
                    state_d = ST_ACQ;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en) begin
            state_d  = ST_IDLE;
            good_d   = '0;
            locked_d = 1'b0;
            err_d    = 1'b0;
            code_d   = ERR_NONE;
            rpt      = 1'b0;
        end
    end

    // State, status flags and the reported period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            good_q     <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            period     <= '0;
            period_vld <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            locked     <= locked_d;
            err        <= err_d;
            err_code   <= code_d;
            period_vld <= rpt;
            if (rpt)
                period <= cyc_q;
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: one DIV=3 instance for lock, period,
// stuck, clear, enable and reset scenarios, one DIV=6 instance for duty error.
module tb_clk_div_monitor;

    logic       clk, rst, en3, en6, mon3, mon6, err_clr;
    logic       locked3, err3, vld3, locked6, err6, vld6;
    logic [1:0] code3, code6;
    logic [7:0] period3, period6;
    int         n_cmp, n_fail;

    clk_div_monitor #(.DIV(3), .CW(8), .LOCK_CNT(4), .TMO(16)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .mon_clk(mon3), .err_clr(err_clr),
        .locked(locked3), .err(err3), .err_code(code3),
        .period(period3), .period_vld(vld3)
    );

    clk_div_monitor #(.DIV(6), .CW(8), .LOCK_CNT(4), .TMO(16)) dut6 (
        .clk(clk), .rst(rst), .en(en6), .mon_clk(mon6), .err_clr(err_clr),
        .locked(locked6), .err(err6), .err_code(code6),
        .period(period6), .period_vld(vld6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive mon_clk levels for one clk cycle, then sample just after the edge
    task automatic tick(input logic m3, input logic m6);
        mon3 = m3;
        mon6 = m6;
        @(posedge clk);
        #1;
    endtask

    // Divide-by-3 (high 2 of 3) starting from ACQ with mon low. Rise actions
    // land on i = 2, 5, 8, ...; first reports nothing, lock on the 5th rise.
    task automatic lock3(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick((i % 3) < 2, 1'b0);
            chk({tag, "/vld"}, vld3, (i >= 5) && ((i - 2) % 3 == 0));
            if ((i >= 5) && ((i - 2) % 3 == 0))
                chk({tag, "/period"}, period3, 3);
            chk({tag, "/locked"}, locked3, i >= 14);
            chk({tag, "/err"}, err3, 0);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; en3 = 1'b0; en6 = 1'b0; mon3 = 1'b0; mon6 = 1'b0; err_clr = 1'b0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst/locked", locked3, 0);
        chk("rst/err", err3, 0);
        chk("rst/code", code3, 0);
        chk("rst/period", period3, 0);
        chk("rst/vld", vld3, 0);
        chk("rst/err6", err6, 0);
        @(posedge clk); #1;
        chk("rst_clk/vld", vld3, 0);
        chk("rst_clk/period", period3, 0);

        // Divide-by-3: lock, then 100+ clean periods
        rst = 1'b1; en3 = 1'b1;
        tick(1'b0, 1'b0);
        chk("acq/locked", locked3, 0);
        lock3(303, "div3");

        // Switch to divide-by-4 while locked: period error
        for (int i = 0; i <= 10; i++) begin
            tick((i % 4) < 2, 1'b0);
            chk("div4/vld", vld3, (i == 2) || (i == 6));
            if (i == 2) chk("div4/period3", period3, 3);
            if (i == 6) chk("div4/period4", period3, 4);
            chk("div4/locked", locked3, i < 6);
            chk("div4/err", err3, i >= 6);
            chk("div4/code", code3, (i >= 6) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            chk("fail_hold/err", err3, 1);
        end

        // Clear and relock
        err_clr = 1'b1;
        tick(1'b0, 1'b0);
        err_clr = 1'b0;
        chk("clr1/err", err3, 0);
        chk("clr1/code", code3, 0);
        lock3(18, "relock1");

        // mon_clk stuck low: error exactly TMO cycles after last rise
        for (int h = 0; h < 16; h++) begin
            tick(1'b0, 1'b0);
            chk("stuck/err", err3, h == 15);
            chk("stuck/locked", locked3, h < 15);
            chk("stuck/code", code3, (h == 15) ? 3 : 0);
        end
        err_clr = 1'b1;
        tick(1'b0, 1'b0);
        err_clr = 1'b0;
        chk("clr2/err", err3, 0);
        chk("clr2/code", code3, 0);
        lock3(18, "relock2");

        // err_clr coincident with a period error: error wins
        for (int i = 0; i <= 7; i++) begin
            if (i == 6) err_clr = 1'b1;
            tick((i % 4) < 2, 1'b0);
            err_clr = 1'b0;
            chk("coinc/vld", vld3, (i == 2) || (i == 6));
            if (i == 6) chk("coinc/period", period3, 4);
            chk("coinc/err", err3, i >= 6);
            chk("coinc/code", code3, (i >= 6) ? 1 : 0);
            chk("coinc/locked", locked3, i < 6);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        err_clr = 1'b1;
        tick(1'b0, 1'b0);
        err_clr = 1'b0;
        lock3(18, "relock3");

        // en dropped in LOCK: idle next cycle, period holds
        en3 = 1'b0;
        tick(1'b0, 1'b0);
        chk("en0/locked", locked3, 0);
        chk("en0/err", err3, 0);
        chk("en0/vld", vld3, 0);
        chk("en0/period", period3, 3);
        for (int i = 0; i < 9; i++) begin
            tick((i % 3) < 2, 1'b0);
            chk("idle/vld", vld3, 0);
            chk("idle/locked", locked3, 0);
            chk("idle/period", period3, 3);
        end

        // DIV=6 with high time 1: duty error on second rise, never locked
        en6 = 1'b1;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, (i % 6) == 0);
            chk("duty/vld", vld6, i == 8);
            if (i == 8) chk("duty/period", period6, 6);
            chk("duty/err", err6, i >= 8);
            chk("duty/code", code6, (i >= 8) ? 2 : 0);
            chk("duty/locked", locked6, 0);
        end

        // Asynchronous reset mid-LOCK
        en3 = 1'b1;
        tick(1'b0, 1'b0);
        lock3(18, "pre_rst");
        #2 rst = 1'b0;
        #1;
        chk("arst/locked", locked3, 0);
        chk("arst/err", err3, 0);
        chk("arst/code", code3, 0);
        chk("arst/period", period3, 0);
        chk("arst/vld", vld3, 0);
        chk("arst/err6", err6, 0);
        #2 rst = 1'b1;
        tick(1'b0, 1'b0);
        lock3(9, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
